// File: rtl/keycode_bank.sv
// rtl/keycode_bank.sv - keycode slot bank with change-event FIFO; stale-key flush built when KEYCODE_BANK_TIMEOUT_EN is defined
module keycode_bank #(
    parameter int N_KEYS         = 4,
    parameter int KW             = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000000,
    localparam int AW            = $clog2(N_KEYS + 1)
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [AW-1:0]        avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 avs_waitrequest,
    output logic [N_KEYS*KW-1:0] keycode_export,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [3:0]           evt_slot,
    output logic [KW-1:0]        evt_old,
    output logic [KW-1:0]        evt_new,
    output logic                 overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] STATUS_ADDR = AW'(N_KEYS);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);

    // Slot registers
    logic [KW-1:0] slot_q [N_KEYS];
    logic [KW-1:0] slot_d [N_KEYS];

    // Event FIFO storage; the head entry is read straight out of the register array
    logic [3:0]    fifo_slot_q [FIFO_DEPTH];
    logic [KW-1:0] fifo_old_q  [FIFO_DEPTH];
    logic [KW-1:0] fifo_new_q  [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          overflow_q, overflow_d;
    logic [31:0]   readdata_q, readdata_d;

    // Single push source per cycle: either a software slot write or a flush step
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic [3:0]    push_slot;
    logic [KW-1:0] push_old;
    logic [KW-1:0] push_new;
    logic          sw_slot_write;

    logic          flush_active;
    logic [AW-1:0] scan_idx;

`ifdef KEYCODE_BANK_TIMEOUT_EN
    typedef enum logic {IDLE, FLUSH} state_e;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] LAST_SLOT  = AW'(N_KEYS - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic [AW-1:0] scan_q, scan_d;
    logic          any_nonzero;

    // Any held key makes a timeout worth flushing
    always_comb begin
        any_nonzero = 1'b0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (slot_q[i] != '0) begin
                any_nonzero = 1'b1;
            end
        end
    end

    // FSM state, idle counter and scan index registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
            scan_q     <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            scan_q     <= scan_d;
        end
    end

    // Idle timeout detection and one-slot-per-cycle flush scan
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        scan_d     = scan_q;
        case (state_q)
            IDLE: begin
                if (sw_slot_write) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LIMIT && any_nonzero) begin
                    state_d = FLUSH;
                    scan_d  = '0;
                end else if (idle_cnt_q != IDLE_LIMIT) begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
            end
            FLUSH: begin
                if (scan_q == LAST_SLOT) begin
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                    scan_d     = '0;
                end else begin
                    scan_d = scan_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign flush_active = (state_q == FLUSH);
    assign scan_idx     = scan_q;
`else
    logic unused_timeout;

    assign flush_active   = 1'b0;
    assign scan_idx       = '0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // Slot next-state and event generation from software writes or the flush scan
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            slot_d[i] = slot_q[i];
        end
        push_req      = 1'b0;
        push_slot     = '0;
        push_old      = '0;
        push_new      = '0;
        sw_slot_write = 1'b0;
        if (flush_active) begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (scan_idx == AW'(i) && slot_q[i] != '0) begin
                    slot_d[i] = '0;
                    push_req  = 1'b1;
                    push_slot = 4'(i);
                    push_old  = slot_q[i];
                    push_new  = '0;
                end
            end
        end else if (avs_write) begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (avs_address == AW'(i)) begin
                    sw_slot_write = 1'b1;
                    slot_d[i]     = avs_writedata[KW-1:0];
                    if (slot_q[i] != avs_writedata[KW-1:0]) begin
                        push_req  = 1'b1;
                        push_slot = 4'(i);
                        push_old  = slot_q[i];
                        push_new  = avs_writedata[KW-1:0];
                    end
                end
            end
        end
    end

    // FIFO bookkeeping: a pop frees room for a same-cycle push; drops set the sticky flag
    always_comb begin
        full     = (count_q == FULL_COUNT);
        pop      = evt_valid && evt_ready;
        push_ok  = push_req && (!full || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q;
        if (!flush_active && avs_write && avs_address == STATUS_ADDR && avs_writedata[31]) begin
            overflow_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    // Read mux, registered for a fixed one-cycle latency; held between reads
    always_comb begin
        readdata_d = readdata_q;
        if (avs_read && !flush_active) begin
            readdata_d = '0;
            if (avs_address == STATUS_ADDR) begin
                readdata_d     = 32'(count_q);
                readdata_d[31] = overflow_q;
            end
            for (int i = 0; i < N_KEYS; i++) begin
                if (avs_address == AW'(i)) begin
                    readdata_d = 32'(slot_q[i]);
                end
            end
        end
    end

    // Slot, pointer, occupancy, flag and read-data registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < N_KEYS; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            readdata_q <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
        end
    end

    // Event storage; cleared on reset so the head fields read 0
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_slot_q[i] <= '0;
                fifo_old_q[i]  <= '0;
                fifo_new_q[i]  <= '0;
            end
        end else if (push_ok) begin
            fifo_slot_q[wr_ptr_q] <= push_slot;
            fifo_old_q[wr_ptr_q]  <= push_old;
            fifo_new_q[wr_ptr_q]  <= push_new;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_export
        assign keycode_export[g*KW +: KW] = slot_q[g];
    end

    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[30:KW];

    assign avs_readdata    = readdata_q;
    assign avs_waitrequest = flush_active;
    assign evt_valid       = (count_q != '0);
    assign evt_slot        = fifo_slot_q[rd_ptr_q];
    assign evt_old         = fifo_old_q[rd_ptr_q];
    assign evt_new         = fifo_new_q[rd_ptr_q];
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_keycode_bank.sv
// tb/tb_keycode_bank.sv - scoreboard bench for keycode_bank with a reference model
module tb_keycode_bank;

    localparam int N     = 4;
    localparam int KW    = 8;
    localparam int DEPTH = 8;
    localparam int TO    = 16;
    localparam int AW    = $clog2(N + 1);

    typedef struct {
        logic [3:0]    s;
        logic [KW-1:0] o;
        logic [KW-1:0] n;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   avs_address = '0;
    logic            avs_read = 1'b0;
    logic            avs_write = 1'b0;
    logic [31:0]     avs_writedata = '0;
    logic [31:0]     avs_readdata;
    logic            avs_waitrequest;
    logic [N*KW-1:0] keycode_export;
    logic            evt_valid;
    logic            evt_ready = 1'b0;
    logic [3:0]      evt_slot;
    logic [KW-1:0]   evt_old;
    logic [KW-1:0]   evt_new;
    logic            overflow;

    int errors = 0;
    int checks = 0;

    ev_t           sb[$];
    logic [KW-1:0] m_slot [N];
    int            m_count = 0;
    logic          m_ovf = 1'b0;
    int            gap = 0;

    keycode_bank #(.N_KEYS(N), .KW(KW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest), .keycode_export(keycode_export),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_slot(evt_slot),
        .evt_old(evt_old), .evt_new(evt_new), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT performs must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                chk("evt_unexpected", 64'(evt_slot), 64'hFFFF);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("evt_slot", 64'(evt_slot), 64'(e.s));
                chk("evt_old", 64'(evt_old), 64'(e.o));
                chk("evt_new", 64'(evt_new), 64'(e.n));
            end
        end
    end

    function automatic logic [N*KW-1:0] model_export();
        logic [N*KW-1:0] v;
        for (int i = 0; i < N; i++) v[i*KW +: KW] = m_slot[i];
        return v;
    endfunction

    // Advance one clock, applying the reference rules to whatever inputs are driven
    task automatic step();
        int          a;
        logic        pop, set_ovf, do_rd, injected;
        logic [31:0] exp_rd;
        injected = 1'b0;
`ifdef KEYCODE_BANK_TIMEOUT_EN
        if (!avs_write && gap >= 8) begin
            avs_write = 1'b1; avs_address = '0; avs_writedata = 32'(m_slot[0]); injected = 1'b1;
        end
`endif
        a = int'(avs_address);
        do_rd = avs_read;
        exp_rd = '0;
        if (a == N) exp_rd = {m_ovf, 15'b0, 16'(m_count)};
        else if (a < N) exp_rd = 32'(m_slot[a]);
        pop = (m_count > 0) && evt_ready;
        set_ovf = 1'b0;
        if (avs_write && a < N) begin
            gap = 0;
            if (avs_writedata[KW-1:0] != m_slot[a]) begin
                if (m_count < DEPTH || pop) begin
                    sb.push_back('{4'(a), m_slot[a], avs_writedata[KW-1:0]});
                    m_count++;
                end else begin
                    set_ovf = 1'b1;
                end
            end
            m_slot[a] = avs_writedata[KW-1:0];
        end else begin
            gap++;
            if (avs_write && a == N && avs_writedata[31]) m_ovf = 1'b0;
        end
        if (set_ovf) m_ovf = 1'b1;
        if (pop) m_count--;
        @(posedge clk); #1;
        if (injected) avs_write = 1'b0;
        chk("export", 64'(keycode_export), 64'(model_export()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (do_rd) chk("readdata", 64'(avs_readdata), 64'(exp_rd));
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = AW'(a); avs_writedata = d;
        step();
        avs_write = 1'b0;
    endtask

    task automatic rd(input int a);
        avs_read = 1'b1; avs_address = AW'(a);
        step();
        avs_read = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        evt_ready = 1'b1;
        while (m_count > 0 && n < 50) begin
            step();
            n++;
        end
        evt_ready = 1'b0;
        step();
        chk("drain_done", 64'(sb.size()), 64'd0);
    endtask

`ifdef KEYCODE_BANK_TIMEOUT_EN
    task automatic wait_flush();
        int n = 0;
        while (!avs_waitrequest && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("flush_started", 64'(avs_waitrequest), 64'd1);
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) m_slot[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_export", 64'(keycode_export), 64'd0);
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_fields", {52'(evt_slot), evt_old, evt_new} >> 0, 64'd0);
        chk("rst_readdata", 64'(avs_readdata), 64'd0);
        chk("rst_wait", 64'(avs_waitrequest), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        wr(1, 32'h04);
        chk("slot1_export", 64'(keycode_export[15:8]), 64'h04);
        rd(N);
        wr(1, 32'h04);
        rd(N);
        drain();

        for (int i = 1; i <= 9; i++) wr(2, 32'(i));
        chk("ovf_set", 64'(overflow), 64'd1);
        rd(N);
        rd(2);
        wr(N, 32'h8000_0000);
        rd(N);
        evt_ready = 1'b1;
        wr(2, 32'hAA);
        evt_ready = 1'b0;
        rd(N);
        drain();

        for (int c = 0; c < 400; c++) begin
            avs_write     = ($urandom_range(0, 1) == 1);
            avs_read      = ($urandom_range(0, 2) == 0);
            avs_address   = AW'($urandom_range(0, (1 << AW) - 1));
            avs_writedata = {($urandom_range(0, 7) == 0), 23'b0, 8'($urandom_range(0, 5))};
            evt_ready     = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            step();
        end
        avs_write = 1'b0; avs_read = 1'b0;
        drain();
        rd(N);

`ifdef KEYCODE_BANK_TIMEOUT_EN
        begin
            int wcnt;
            wr(0, 32'h1A); wr(1, 32'h00); wr(2, 32'h2C); wr(3, 32'h00);
            drain();
            wait_flush();
            avs_write = 1'b1; avs_address = AW'(3); avs_writedata = 32'h55;
            wcnt = 0;
            while (avs_waitrequest && wcnt < 20) begin
                @(posedge clk); #1;
                wcnt++;
            end
            chk("flush_cycles", 64'(wcnt), 64'(N));
            @(posedge clk); #1;
            avs_write = 1'b0;
            sb.push_back('{4'd0, 8'h1A, 8'h00});
            sb.push_back('{4'd2, 8'h2C, 8'h00});
            sb.push_back('{4'd3, 8'h00, 8'h55});
            m_count = 3; m_slot[0] = '0; m_slot[2] = '0; m_slot[3] = 8'h55; gap = 0;
            chk("flush_export", 64'(keycode_export), 64'(model_export()));
            rd(N);
            drain();

            wr(1, 32'h33);
            drain();
            wait_flush();
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            for (int i = 0; i < N; i++) m_slot[i] = '0;
            m_count = 0; m_ovf = 1'b0; sb.delete(); gap = 0;
            chk("rstflush_wait", 64'(avs_waitrequest), 64'd0);
            chk("rstflush_valid", 64'(evt_valid), 64'd0);
            chk("rstflush_export", 64'(keycode_export), 64'd0);
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                chk("rstflush_quiet", 64'({evt_valid, avs_waitrequest}), 64'd0);
            end
            rd(N);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
